hack_cpu_ctrl: RTL and testbench

Hack-ISA control and register unit that drives the six ALU control bits and both operands, and consumes the ALU result. It decodes one 16-bit instruction per cycle, holds the A register, D register and PC, generates data-memory write strobes, and resolves conditional jumps. It sits between instruction ROM, data RAM and an external combinational alu instance; together they form the cpu.

---
 rtl/hack_cpu_ctrl.sv | 96 +++++++++
 tb/tb_hack_cpu_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/hack_cpu_ctrl.sv
// Hack-ISA control/register unit: decodes one instruction, feeds an external ALU, holds A/D/PC.
// Latency: combinational ALU/memory drive in the fetch cycle; register effects visible after the edge.
// Backpressure: instr_valid=0 stalls; A, D and pc hold and write_m is forced low.
module hack_cpu_ctrl #(
  parameter int WORDSIZE = 16,
  parameter int PC_W     = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORDSIZE-1:0] instr,
  input  logic                instr_valid,
  input  logic [WORDSIZE-1:0] in_m,
  input  logic [WORDSIZE-1:0] alu_out,
  output logic [WORDSIZE-1:0] alu_x,
  output logic [WORDSIZE-1:0] alu_y,
  output logic                zx,
  output logic                nx,
  output logic                zy,
  output logic                ny,
  output logic                f,
  output logic                no,
  output logic [WORDSIZE-1:0] out_m,
  output logic                write_m,
  output logic [PC_W-1:0]     address_m,
  output logic [PC_W-1:0]     pc,
  output logic [WORDSIZE-1:0] d_reg
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  logic [WORDSIZE-1:0] a_reg;

  // Instruction fields; bits [14:13] of a C-instruction carry no meaning.
  logic       is_c;
  logic       a_sel;
  logic [2:0] dest;
  logic [2:0] jump;
  logic       zero;
  logic       neg;
  logic       take;
  logic [PC_W-1:0] pc_inc;

  assign is_c   = instr[WORDSIZE-1];
  assign a_sel  = instr[12];
  assign dest   = instr[5:3];
  assign jump   = instr[2:0];
  assign pc_inc = pc + PC_ONE;

  // Drive ALU operands/controls and derive jump condition from the ALU result.
  always_comb begin
    alu_x = d_reg;
    alu_y = a_reg;
    zx    = 1'b0;
    nx    = 1'b0;
    zy    = 1'b0;
    ny    = 1'b0;
    f     = 1'b0;
    no    = 1'b0;
    if (is_c) begin
      alu_y = a_sel ? in_m : a_reg;
      zx    = instr[11];
      nx    = instr[10];
      zy    = instr[9];
      ny    = instr[8];
      f     = instr[7];
      no    = instr[6];
    end
    zero = (alu_out == '0);
    neg  = alu_out[WORDSIZE-1];
    take = is_c & ((jump[2] & neg) | (jump[1] & zero) | (jump[0] & ~neg & ~zero));
  end

  // Memory side is same-cycle; address uses A before this instruction's update.
  assign out_m     = alu_out;
  assign address_m = a_reg[PC_W-1:0];
  assign write_m   = instr_valid & is_c & dest[0] & ~rst;

  // Register update: jump target is the old A, A/D both capture the same alu_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      d_reg <= '0;
      pc    <= '0;
    end else if (instr_valid) begin
      if (!is_c) begin
        a_reg <= {1'b0, instr[WORDSIZE-2:0]};
        pc    <= pc_inc;
      end else begin
        if (dest[2]) a_reg <= alu_out;
        if (dest[1]) d_reg <= alu_out;
        pc <= take ? a_reg[PC_W-1:0] : pc_inc;
      end
    end
  end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
module tb_hack_cpu_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] in_m;
  logic [15:0] alu_out;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic        zx, nx, zy, ny, f, no;
  logic [15:0] out_m;
  logic        write_m;
  logic [14:0] address_m;
  logic [14:0] pc;
  logic [15:0] d_reg;

  int checks = 0;
  int errors = 0;

  hack_cpu_ctrl #(.WORDSIZE(16), .PC_W(15)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .in_m(in_m), .alu_out(alu_out), .alu_x(alu_x), .alu_y(alu_y),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .out_m(out_m), .write_m(write_m), .address_m(address_m),
    .pc(pc), .d_reg(d_reg)
  );

  // Reference Hack ALU standing in for the external alu instance.
  logic [15:0] ax, ay, ar;
  always_comb begin
    ax = zx ? 16'h0000 : alu_x;
    ax = nx ? ~ax : ax;
    ay = zy ? 16'h0000 : alu_y;
    ay = ny ? ~ay : ay;
    ar = f ? (ax + ay) : (ax & ay);
    ar = no ? ~ar : ar;
  end
  assign alu_out = ar;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] instr;
    logic        vld;
    logic [15:0] in_m;
    logic        wm;
    logic        chk_out;
    logic [15:0] out;
    logic [14:0] addr;
    logic [14:0] pc_n;
    logic [14:0] a_n;
    logic [15:0] d_n;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(input logic [15:0] i, input logic v, input logic [15:0] m,
                              input logic wm, input logic co, input logic [15:0] o,
                              input logic [14:0] ad, input logic [14:0] p,
                              input logic [14:0] a, input logic [15:0] d);
    vec_t r;
    r.instr = i; r.vld = v; r.in_m = m; r.wm = wm; r.chk_out = co; r.out = o;
    r.addr = ad; r.pc_n = p; r.a_n = a; r.d_n = d;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_row(input int idx, input vec_t v);
    vec_t e;
    @(negedge clk);
    instr = v.instr;
    instr_valid = v.vld;
    in_m = v.in_m;
    sb.push_back(v);
    #2;
    e = sb.pop_front();
    chk($sformatf("row%0d write_m", idx), {15'h0, write_m}, {15'h0, e.wm});
    chk($sformatf("row%0d address_m", idx), {1'b0, address_m}, {1'b0, e.addr});
    if (e.chk_out) chk($sformatf("row%0d out_m", idx), out_m, e.out);
    @(posedge clk);
    #1;
    chk($sformatf("row%0d pc", idx), {1'b0, pc}, {1'b0, e.pc_n});
    chk($sformatf("row%0d A", idx), {1'b0, address_m}, {1'b0, e.a_n});
    chk($sformatf("row%0d D", idx), d_reg, e.d_n);
  endtask

  initial begin
    rst = 1'b1;
    instr = 16'h0000;
    instr_valid = 1'b0;
    in_m = 16'h0000;

    // Program: load/copy, memory write, conditional jumps, RMW, AD write, jump to old A.
    tbl.push_back(mk(16'h0015, 1, 0, 0, 0, 0, 15'd0,   15'd1,   15'd21,  16'd0));
    tbl.push_back(mk(16'hEC10, 1, 0, 0, 0, 0, 15'd21,  15'd2,   15'd21,  16'd21));
    tbl.push_back(mk(16'h0007, 1, 0, 0, 0, 0, 15'd21,  15'd3,   15'd7,   16'd21));
    tbl.push_back(mk(16'hEC10, 1, 0, 0, 0, 0, 15'd7,   15'd4,   15'd7,   16'd7));
    tbl.push_back(mk(16'h0015, 1, 0, 0, 0, 0, 15'd7,   15'd5,   15'd21,  16'd7));
    tbl.push_back(mk(16'hE308, 1, 0, 1, 1, 16'd7, 15'd21, 15'd6, 15'd21, 16'd7));
    tbl.push_back(mk(16'h0064, 1, 0, 0, 0, 0, 15'd21,  15'd7,   15'd100, 16'd7));
    tbl.push_back(mk(16'hE302, 1, 0, 0, 0, 0, 15'd100, 15'd8,   15'd100, 16'd7));
    tbl.push_back(mk(16'h0000, 1, 0, 0, 0, 0, 15'd100, 15'd9,   15'd0,   16'd7));
    tbl.push_back(mk(16'hEC10, 1, 0, 0, 0, 0, 15'd0,   15'd10,  15'd0,   16'd0));
    tbl.push_back(mk(16'h0064, 1, 0, 0, 0, 0, 15'd0,   15'd11,  15'd100, 16'd0));
    tbl.push_back(mk(16'hE302, 1, 0, 0, 0, 0, 15'd100, 15'd100, 15'd100, 16'd0));
    tbl.push_back(mk(16'h0005, 1, 0, 0, 0, 0, 15'd100, 15'd101, 15'd5,   16'd0));
    tbl.push_back(mk(16'hEC10, 1, 0, 0, 0, 0, 15'd5,   15'd102, 15'd5,   16'd5));
    tbl.push_back(mk(16'h0064, 1, 0, 0, 0, 0, 15'd5,   15'd103, 15'd100, 16'd5));
    tbl.push_back(mk(16'hE302, 1, 0, 0, 0, 0, 15'd100, 15'd104, 15'd100, 16'd5));
    tbl.push_back(mk(16'hE3D0, 1, 0, 0, 0, 0, 15'd100, 15'd105, 15'd100, 16'hFFFB));
    tbl.push_back(mk(16'hE304, 1, 0, 0, 0, 0, 15'd100, 15'd100, 15'd100, 16'hFFFB));
    tbl.push_back(mk(16'h001E, 1, 0, 0, 0, 0, 15'd100, 15'd101, 15'd30,  16'hFFFB));
    tbl.push_back(mk(16'hFDE8, 1, 9, 1, 1, 16'd10, 15'd30, 15'd102, 15'd10, 16'hFFFB));
    tbl.push_back(mk(16'hEA87, 1, 0, 0, 0, 0, 15'd10,  15'd10,  15'd10,  16'hFFFB));
    tbl.push_back(mk(16'hEDF0, 1, 0, 0, 0, 0, 15'd10,  15'd11,  15'd11,  16'd11));
    tbl.push_back(mk(16'hEDE7, 1, 0, 0, 0, 0, 15'd11,  15'd11,  15'd12,  16'd11));
    // Stall with a memory-write instruction present.
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(16'hE308, 0, 0, 0, 0, 0, 15'd12, 15'd11, 15'd12, 16'd11));
    // PC wrap from 0x7FFF.
    tbl.push_back(mk(16'h7FFF, 1, 0, 0, 0, 0, 15'd12,     15'd12,     15'h7FFF, 16'd11));
    tbl.push_back(mk(16'hEA87, 1, 0, 0, 0, 0, 15'h7FFF,   15'h7FFF,   15'h7FFF, 16'd11));
    tbl.push_back(mk(16'h0003, 1, 0, 0, 0, 0, 15'h7FFF,   15'd0,      15'd3,    16'd11));
    // Advance to pc=5 for the asynchronous reset sequence.
    tbl.push_back(mk(16'h0001, 1, 0, 0, 0, 0, 15'd3, 15'd1, 15'd1, 16'd11));
    tbl.push_back(mk(16'h0002, 1, 0, 0, 0, 0, 15'd1, 15'd2, 15'd2, 16'd11));
    tbl.push_back(mk(16'h0003, 1, 0, 0, 0, 0, 15'd2, 15'd3, 15'd3, 16'd11));
    tbl.push_back(mk(16'h0004, 1, 0, 0, 0, 0, 15'd3, 15'd4, 15'd4, 16'd11));
    tbl.push_back(mk(16'h0005, 1, 0, 0, 0, 0, 15'd4, 15'd5, 15'd5, 16'd11));

    // Reset state.
    #2;
    chk("reset pc", {1'b0, pc}, 16'h0000);
    chk("reset A", {1'b0, address_m}, 16'h0000);
    chk("reset D", d_reg, 16'h0000);
    chk("reset write_m", {15'h0, write_m}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) run_row(i, tbl[i]);

    // Asynchronous reset in the middle of a write instruction.
    @(negedge clk);
    instr = 16'hE308;
    instr_valid = 1'b1;
    in_m = 16'h0000;
    #1;
    chk("pre-reset write_m", {15'h0, write_m}, 16'h0001);
    chk("pre-reset out_m", out_m, 16'd11);
    #1;
    rst = 1'b1;
    #1;
    chk("async reset pc", {1'b0, pc}, 16'h0000);
    chk("async reset A", {1'b0, address_m}, 16'h0000);
    chk("async reset D", d_reg, 16'h0000);
    chk("async reset write_m", {15'h0, write_m}, 16'h0000);
    @(posedge clk);
    #1;
    chk("held reset pc", {1'b0, pc}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    instr = 16'h0009;
    #1;
    chk("first fetch pc", {1'b0, pc}, 16'h0000);
    @(posedge clk);
    #1;
    chk("post-reset pc", {1'b0, pc}, 16'h0001);
    chk("post-reset A", {1'b0, address_m}, 16'h0009);
    chk("post-reset D", d_reg, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
